fir_out_packer: RTL and testbench
=================================

// Module: fir_out_packer
// PURPOSE
//  Output stage downstream of the W4823 FIR ALU. Captures the normalized FP29i accumulation
//  result on a strobe from the FIR state controller and rounds it to IEEE FP16
//  (round-to-nearest-even, denormals flushed, overflow saturated to inf).
//  Results are buffered in a small FIFO and handed to the consumer over a valid/ready handshake.
// PARAMETERS
//  DEPTH      4   FIFO entries (power of 2, >=2)
//  EXP_BIAS  15   exponent bias of FP29i result (same as FP16)
// PORTS
//  clk_fast    in   1   fast clock, all state on posedge
//  rst_n       in   1   asynchronous, active-low reset
//  cap_en      in   1   1-cycle strobe: din_29i holds final normalized result
//  din_29i     in  29   {sgn[28], exp[27:22], man[21:0]}, man[21] = hidden one
//  out_ready   in   1   consumer accepts out_data this cycle
//  clr_flags   in   1   clears sticky flags
//  out_valid   out  1   out_data holds a valid FP16 word
//  out_data    out 16   FP16 word at FIFO head
//  fifo_level  out  $clog2(DEPTH)+1  entries held
//  oflow_flg   out  1   sticky: a result saturated to inf
//  uflow_flg   out  1   sticky: a nonzero result flushed to zero
//  ovr_flg     out  1   sticky: a result was dropped, FIFO full
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, pipeline valids 0; async assert, sync-safe deassert.
//  S1 (capture): on cap_en, register din_29i and set v1; v1 clears the next cycle unless cap_en is high again.
//  S2 (round/pack): from the S1 register:
//   - frac = man[20:11], lsb = man[11], g = man[10], st = |man[9:0].
//   - up = g & (st | lsb); {c, f} = frac + up; e = exp + c (7-bit, no wrap).
//   - man[21]==0 -> {sgn, 15'h0}, no flag.
//   - e==0 -> {sgn, 15'h0}, uflow event.
//   - e >= 31 -> {sgn, 5'h1F, 10'h0}, oflow event.
//   - otherwise {sgn, e[4:0], f}.
//   - The S2 result is pushed into the FIFO at the end of the S2 cycle.
//  Latency: cap_en in cycle N -> FIFO write at edge N+2 -> out_valid=1 in cycle N+2 if the FIFO was empty.
//  Throughput: one capture per cycle is sustained.
//  FIFO: circular, wr/rd pointers one bit wider than the address; full when addresses are equal and MSBs differ.
//   - Pop when out_valid & out_ready. out_data = mem[rd_ptr], no bubble.
//   - Push with FIFO full and no pop: result is dropped, contents are unchanged, ovr event.
//   - Push and pop in the same cycle: legal when full (level unchanged, no drop) and when empty-with-push-only.
//   - Pop when empty: ignored.
//   - Pointers wrap modulo 2*DEPTH.
//  out_data is stable while out_valid & ~out_ready.
//  Flags: set on the event cycle and held until clr_flags.
//   - clr_flags coincident with a new event: the set wins.
//  rst_n asserted mid-operation: pipeline and FIFO contents are lost, outputs return to reset values immediately.
// TESTING
//  1) din=0x03E00000 (exp 15, man 0x200000), cap_en, out_ready=1 -> out_data=0x3C00 at N+2, 1-cycle out_valid.
//  2) Tie: man=0x200400 -> 0x3C00 (even, no round); man=0x200C00 -> 0x3C02; man=0x200401 -> 0x3C01.
//  3) Carry: exp 15, man=0x3FFC00 -> 0x4000. Overflow: exp 31, man=0x200000, sgn=1 -> 0xFC00, oflow_flg=1.
//  4) Underflow: exp 0, man=0x200000 -> 0x0000, uflow_flg=1. man=0 with any exp -> signed zero, no flag.
//  5) out_ready=0, 5 back-to-back cap_en -> fifo_level=4, ovr_flg=1, first 4 results drained in order.
//  6) Full FIFO, push+pop same cycle -> level stays 4, no drop. Flag persistence: clr_flags with a new oflow -> flag stays 1.
//     Reset mid-drain -> out_valid=0, level 0.

Source files
------------

// File: rtl/fir_out_packer_if.sv
// Bus between the FIR controller/consumer side and the FP16 output packer.
interface fir_out_packer_if #(
   parameter int unsigned DEPTH = 4
);
   localparam int unsigned LW = $clog2(DEPTH) + 1;

   logic          cap_en;
   logic [28:0]   din_29i;
   logic          out_ready;
   logic          clr_flags;
   logic          out_valid;
   logic [15:0]   out_data;
   logic [LW-1:0] fifo_level;
   logic          oflow_flg;
   logic          uflow_flg;
   logic          ovr_flg;

   modport master (
      output cap_en, din_29i, out_ready, clr_flags,
      input  out_valid, out_data, fifo_level, oflow_flg, uflow_flg, ovr_flg
   );

   modport slave (
      input  cap_en, din_29i, out_ready, clr_flags,
      output out_valid, out_data, fifo_level, oflow_flg, uflow_flg, ovr_flg
   );
endinterface

// File: rtl/fir_out_packer.sv
// FP29i -> FP16 rounding stage (RNE, flush-to-zero, saturate-to-inf) with an
// output FIFO and valid/ready handshake.
module fir_out_packer #(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned EXP_BIAS = 15
) (
   input  logic              clk_fast,
   input  logic              rst_n,
   fir_out_packer_if.slave   bus
);
   localparam int unsigned AW   = $clog2(DEPTH);
   localparam int unsigned LW   = AW + 1;
   localparam int unsigned EMAX = 2 * EXP_BIAS + 1;

   typedef struct packed {
      logic        sgn;
      logic [5:0]  exp;
      logic [21:0] man;
   } fp29_t;

   fp29_t         s1_q;
   logic          v1_q;

   logic [9:0]    frac;
   logic          rnd_up;
   logic [10:0]   frac_rnd;
   logic [6:0]    exp_rnd;
   logic [15:0]   pack_c;
   logic          oflow_ev_c;
   logic          uflow_ev_c;

   logic [15:0]   mem [DEPTH];
   logic [LW-1:0] wr_ptr;
   logic [LW-1:0] rd_ptr;
   logic [LW-1:0] level_q;
   logic [LW-1:0] level_nxt;
   logic          valid_q;
   logic          full_c;
   logic          pop_c;
   logic          wr_en_c;
   logic          drop_c;
   logic          oflow_q;
   logic          uflow_q;
   logic          ovr_q;

   // S1: capture the final accumulation result
   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
         s1_q <= '0;
         v1_q <= 1'b0;
      end else begin
         v1_q <= bus.cap_en;
         if (bus.cap_en) s1_q <= bus.din_29i;
      end
   end

   // S2: round-to-nearest-even into FP16, classify special results
   always_comb begin
      frac       = s1_q.man[20:11];
      rnd_up     = s1_q.man[10] & ((|s1_q.man[9:0]) | s1_q.man[11]);
      frac_rnd   = {1'b0, frac} + 11'(rnd_up);
      exp_rnd    = {1'b0, s1_q.exp} + 7'(frac_rnd[10]);
      pack_c     = {s1_q.sgn, 15'h0};
      oflow_ev_c = 1'b0;
      uflow_ev_c = 1'b0;
      if (!s1_q.man[21]) begin
         pack_c = {s1_q.sgn, 15'h0};
      end else if (exp_rnd == 7'd0) begin
         uflow_ev_c = v1_q;
      end else if (exp_rnd >= 7'(EMAX)) begin
         pack_c     = {s1_q.sgn, 5'h1F, 10'h0};
         oflow_ev_c = v1_q;
      end else begin
         pack_c = {s1_q.sgn, exp_rnd[4:0], frac_rnd[9:0]};
      end
   end

   // FIFO control; a full FIFO still accepts a push when the head pops
   always_comb begin
      full_c    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
      pop_c     = valid_q & bus.out_ready;
      wr_en_c   = v1_q & (~full_c | pop_c);
      drop_c    = v1_q & full_c & ~pop_c;
      level_nxt = level_q + LW'(wr_en_c) - LW'(pop_c);
   end

   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         valid_q <= 1'b0;
      end else begin
         if (wr_en_c) begin
            mem[wr_ptr[AW-1:0]] <= pack_c;
            wr_ptr              <= wr_ptr + LW'(1);
         end
         if (pop_c) rd_ptr <= rd_ptr + LW'(1);
         level_q <= level_nxt;
         valid_q <= (level_nxt != '0);
      end
   end

   // Sticky flags: a new event wins over a coincident clear
   always_ff @(posedge clk_fast or negedge rst_n) begin
      if (!rst_n) begin
         oflow_q <= 1'b0;
         uflow_q <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         oflow_q <= oflow_ev_c | (oflow_q & ~bus.clr_flags);
         uflow_q <= uflow_ev_c | (uflow_q & ~bus.clr_flags);
         ovr_q   <= drop_c     | (ovr_q   & ~bus.clr_flags);
      end
   end

   assign bus.out_valid  = valid_q;
   assign bus.out_data   = mem[rd_ptr[AW-1:0]];
   assign bus.fifo_level = level_q;
   assign bus.oflow_flg  = oflow_q;
   assign bus.uflow_flg  = uflow_q;
   assign bus.ovr_flg    = ovr_q;
endmodule

// File: tb/tb_fir_out_packer.sv
// Directed + randomized bench for fir_out_packer against a queue-based FP16 reference model.
module tb_fir_out_packer;
   localparam int unsigned DEPTH = 4;

   logic clk_fast;
   logic rst_n;
   int   n_cmp;
   int   n_err;

   fir_out_packer_if #(.DEPTH(DEPTH)) bus ();

   fir_out_packer #(.DEPTH(DEPTH), .EXP_BIAS(15)) dut (
      .clk_fast (clk_fast),
      .rst_n    (rst_n),
      .bus      (bus)
   );

   initial clk_fast = 1'b0;
   always #5 clk_fast = ~clk_fast;

   // Reference state: result queue, one captured-but-unpushed word, sticky flags
   logic [15:0] mq[$];
   bit          pend_v;
   logic [28:0] pend_d;
   bit          m_of, m_uf, m_ovr;

   function automatic logic [28:0] mk(input bit s, input int e, input int m);
      logic [5:0]  e6 = 6'(e);
      logic [21:0] m22 = 22'(m);
      return {s, e6, m22};
   endfunction

   // FP29i value 1.f * 2^(e-15) rounded to FP16 using integer remainder arithmetic
   function automatic void fp_model(input logic [28:0] d, output logic [15:0] r,
                                    output bit ov, output bit un);
      bit s = d[28];
      int e = int'(d[27:22]);
      int m = int'(d[21:0]);
      int q;
      int rem;
      ov = 0;
      un = 0;
      if (m < 'h200000) begin
         r = {s, 15'h0};
      end else begin
         q   = m / 2048;
         rem = m % 2048;
         if (rem > 1024 || (rem == 1024 && (q % 2) == 1)) q = q + 1;
         if (q == 4096) begin
            q = 2048;
         end
         if (q == 2048) begin
            q = 1024;
            e = e + 1;
         end
         if (e == 0) begin
            r  = {s, 15'h0};
            un = 1;
         end else if (e >= 31) begin
            r  = {s, 15'h7C00};
            ov = 1;
         end else begin
            r = {s, 5'(e), 10'(q - 1024)};
         end
      end
   endfunction

   function automatic void model_edge(input bit cap, input logic [28:0] din,
                                      input bit rdy, input bit clr);
      bit          pop = (mq.size() > 0) && rdy;
      bit          ev_of = 0, ev_uf = 0, ev_ovr = 0;
      logic [15:0] r;
      if (pop) void'(mq.pop_front());
      if (pend_v) begin
         fp_model(pend_d, r, ev_of, ev_uf);
         if (mq.size() < DEPTH) mq.push_back(r);
         else ev_ovr = 1;
      end
      m_of   = ev_of  | (m_of  & ~clr);
      m_uf   = ev_uf  | (m_uf  & ~clr);
      m_ovr  = ev_ovr | (m_ovr & ~clr);
      pend_v = cap;
      pend_d = din;
   endfunction

   function automatic void model_reset();
      mq.delete();
      pend_v = 0;
      pend_d = '0;
      m_of   = 0;
      m_uf   = 0;
      m_ovr  = 0;
   endfunction

   task automatic check_outputs(input string tag);
      logic       exp_v = (mq.size() > 0);
      logic [2:0] exp_l = 3'(mq.size());
      n_cmp++;
      assert (bus.out_valid === exp_v) else begin
         n_err++;
         $error("FAIL %s out_valid: observed %b expected %b", tag, bus.out_valid, exp_v);
      end
      n_cmp++;
      assert (bus.fifo_level === exp_l) else begin
         n_err++;
         $error("FAIL %s fifo_level: observed %0d expected %0d", tag, bus.fifo_level, exp_l);
      end
      if (exp_v) begin
         n_cmp++;
         assert (bus.out_data === mq[0]) else begin
            n_err++;
            $error("FAIL %s out_data: observed %h expected %h", tag, bus.out_data, mq[0]);
         end
      end
      n_cmp++;
      assert ({bus.oflow_flg, bus.uflow_flg, bus.ovr_flg} === {m_of, m_uf, m_ovr}) else begin
         n_err++;
         $error("FAIL %s flags(of,uf,ovr): observed %b%b%b expected %b%b%b", tag,
                bus.oflow_flg, bus.uflow_flg, bus.ovr_flg, m_of, m_uf, m_ovr);
      end
   endtask

   task automatic check_reset_state(input string tag);
      n_cmp++;
      assert ({bus.out_valid, bus.fifo_level, bus.oflow_flg, bus.uflow_flg, bus.ovr_flg} === 7'b0)
      else begin
         n_err++;
         $error("FAIL %s state: observed v=%b lvl=%0d f=%b%b%b expected all 0", tag,
                bus.out_valid, bus.fifo_level, bus.oflow_flg, bus.uflow_flg, bus.ovr_flg);
      end
      n_cmp++;
      assert (bus.out_data === 16'h0000) else begin
         n_err++;
         $error("FAIL %s out_data: observed %h expected 0000", tag, bus.out_data);
      end
   endtask

   task automatic step(input bit cap, input logic [28:0] din, input bit rdy,
                       input bit clr, input string tag);
      @(negedge clk_fast);
      bus.cap_en    = cap;
      bus.din_29i   = din;
      bus.out_ready = rdy;
      bus.clr_flags = clr;
      @(posedge clk_fast);
      model_edge(cap, din, rdy, clr);
      #1;
      check_outputs(tag);
   endtask

   function automatic logic [28:0] rand_din();
      int          e = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 63))
                                                   : int'($urandom_range(0, 32));
      logic [21:0] m = 22'($urandom);
      if ($urandom_range(0, 9) != 0) m[21] = 1'b1;
      if ($urandom_range(0, 4) == 0) m[10:0] = 11'h400;
      if ($urandom_range(0, 9) == 0) m[20:0] = 21'h1FFFFF;
      return {1'($urandom), 6'(e), m};
   endfunction

   initial begin
      n_cmp = 0;
      n_err = 0;
      model_reset();
      bus.cap_en    = 1'b0;
      bus.din_29i   = '0;
      bus.out_ready = 1'b0;
      bus.clr_flags = 1'b0;
      rst_n         = 1'b0;
      repeat (2) @(posedge clk_fast);
      #1;
      check_reset_state("reset");
      @(negedge clk_fast);
      rst_n = 1'b1;

      // Basic latency and single-cycle valid
      step(1, 29'h03E00000, 1, 0, "basic_cap");
      step(0, '0, 1, 0, "basic_s2");
      step(0, '0, 1, 0, "basic_valid");
      step(0, '0, 1, 0, "basic_drained");

      // Ties and rounding
      step(1, mk(0, 15, 'h200400), 1, 0, "tie_even");
      step(1, mk(0, 15, 'h200C00), 1, 0, "tie_odd");
      step(1, mk(0, 15, 'h200401), 1, 0, "above_half");
      step(1, mk(0, 15, 'h3FFC00), 1, 0, "carry");
      step(1, mk(1, 31, 'h200000), 1, 0, "oflow");
      step(1, mk(0, 0,  'h200000), 1, 0, "uflow");
      step(1, mk(1, 40, 0),        1, 0, "zero_man");
      repeat (3) step(0, '0, 1, 0, "dir_drain");
      step(0, '0, 1, 1, "clr");

      // Overrun with stalled consumer, then in-order drain
      repeat (5) step(1, rand_din(), 0, 0, "ovr_fill");
      repeat (2) step(0, '0, 0, 0, "ovr_hold");
      repeat (5) step(0, '0, 1, 0, "ovr_drain");
      step(0, '0, 0, 1, "clr2");

      // Full FIFO with simultaneous push and pop
      repeat (6) step(1, rand_din(), 0, 0, "full_fill");
      step(1, rand_din(), 1, 1, "full_pp_clr");
      repeat (5) step(1, rand_din(), 1, 0, "full_pp");
      repeat (6) step(0, '0, 1, 1, "full_drain");

      // Clear coincident with a new overflow event
      step(1, mk(0, 50, 'h2ABCDE), 1, 0, "clr_race_cap");
      step(0, '0, 1, 1, "clr_race_ev");
      step(0, '0, 1, 0, "clr_race_hold");
      step(0, '0, 1, 1, "clr_race_clr");

      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 9) < 6), rand_din(), ($urandom_range(0, 9) < 5),
              ($urandom_range(0, 19) == 0), "rand");
      end

      // Reset asserted mid-drain
      repeat (6) step(1, rand_din(), 0, 0, "pre_rst_fill");
      step(0, '0, 1, 0, "pre_rst_drain");
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_reset_state("mid_reset");
      @(negedge clk_fast);
      rst_n = 1'b1;
      step(0, '0, 1, 0, "post_rst_idle");
      step(1, 29'h03E00000, 0, 0, "post_rst_cap");
      repeat (3) step(0, '0, 0, 0, "post_rst_hold");
      repeat (2) step(0, '0, 1, 0, "post_rst_drain");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
